tdp_ram: RTL and testbench

Synchronous true-dual-port RAM, 2^ADDR_WIDTH words × DATA_WIDTH bits, two independent read/write ports on one clock. Serves as the character/colour store behind display peripherals (e.g. VRAM: port A written by the CPU side, port B read by the scan-out side) and as a general on-chip buffer. Registered read outputs; vendor memory style passed through as a synthesis hint.

---
 rtl/tdp_ram.sv | 66 ++++++
 tb/tb_tdp_ram.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tdp_ram.sv
// True-dual-port synchronous RAM on one clock with registered read outputs.
// Define TDP_RAM_OUTREG_EN to add a second output register stage, giving a read latency of 2.
module tdp_ram #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 56,
  parameter string       RAM_STYLE  = "MLAB"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Contents power up as zero; reset never touches the array.
  (* ramstyle = RAM_STYLE *) logic [DATA_WIDTH-1:0] memArray [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] qA1;
  logic [DATA_WIDTH-1:0] qB1;

  // Port A is written last so it wins a same-address write collision; reads see
  // pre-edge contents (read-first across ports) and own write data (write-first).
  always_ff @(posedge clk) begin
    if (reset) begin
      qA1 <= '0;
      qB1 <= '0;
    end else begin
      if (wren_b) memArray[address_b] <= data_b;
      if (wren_a) memArray[address_a] <= data_a;
      if (rden_a) qA1 <= wren_a ? data_a : memArray[address_a];
      if (rden_b) qB1 <= wren_b ? data_b : memArray[address_b];
    end
  end

`ifdef TDP_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] qA2;
  logic [DATA_WIDTH-1:0] qB2;

  // Free-running second stage; hold behaviour comes from the first stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      qA2 <= '0;
      qB2 <= '0;
    end else begin
      qA2 <= qA1;
      qB2 <= qB1;
    end
  end

  assign q_a = qA2;
  assign q_b = qB2;
`else
  assign q_a = qA1;
  assign q_b = qB1;
`endif

endmodule

// File: tb/tb_tdp_ram.sv
// Directed self-checking bench for tdp_ram with hand-computed expected values.
module tb_tdp_ram;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 56;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b, rden_a, rden_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] q_a, q_b;

  int errors = 0;
  int checks = 0;

  tdp_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_STYLE("MLAB")) dut (
    .clk(clk), .reset(reset),
    .address_a(address_a), .wren_a(wren_a), .data_a(data_a), .rden_a(rden_a), .q_a(q_a),
    .address_b(address_b), .wren_b(wren_b), .data_b(data_b), .rden_b(rden_b), .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
  endtask

  // Lets the optional output stage catch up; enables are off so first stage holds.
  task automatic settle();
`ifdef TDP_RAM_OUTREG_EN
    idle();
    tick();
`endif
  endtask

  task automatic portA(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] d, input logic rd);
    address_a = addr; wren_a = wr; data_a = d; rden_a = rd;
  endtask

  task automatic portB(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] d, input logic rd);
    address_b = addr; wren_b = wr; data_b = d; rden_b = rd;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    address_a = '0; address_b = '0; data_a = '0; data_b = '0;

    // Reset with reads requested
    portA(11'd0, 1'b0, '0, 1'b1);
    portB(11'd0, 1'b0, '0, 1'b1);
    tick();
    tick();
    checkEq("rst_qa", q_a, 56'h0);
    checkEq("rst_qb", q_b, 56'h0);

    // Initial contents read as zero
    reset = 1'b0;
    portA(11'd5, 1'b0, '0, 1'b1);
    portB(11'd5, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("init_qa", q_a, 56'h0);
    checkEq("init_qb", q_b, 56'h0);

    // A writes, B reads back next cycle
    idle(); portA(11'h123, 1'b1, 56'hDEADBEEF00, 1'b0);
    tick();
    idle(); portB(11'h123, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("basic_qb", q_b, 56'hDEADBEEF00);

    // Cross-port collision: B sees old contents, then new
    idle(); portA(11'd7, 1'b1, 56'h11, 1'b0);
    tick();
    portA(11'd7, 1'b1, 56'h22, 1'b0);
    portB(11'd7, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("xport_old", q_b, 56'h11);
    idle(); portB(11'd7, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("xport_new", q_b, 56'h22);

    // Write-write collision: A wins, each port reads back its own data
    portA(11'd9, 1'b1, 56'hAA, 1'b1);
    portB(11'd9, 1'b1, 56'hBB, 1'b1);
    tick(); settle();
    checkEq("ww_own_qa", q_a, 56'hAA);
    checkEq("ww_own_qb", q_b, 56'hBB);
    portA(11'd9, 1'b0, '0, 1'b1);
    portB(11'd9, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("ww_win_qa", q_a, 56'hAA);
    checkEq("ww_win_qb", q_b, 56'hAA);

    // Same-port write-first, then hold with rden low
    idle(); portA(11'd3, 1'b1, 56'h55, 1'b1);
    tick(); settle();
    checkEq("rdw_qa", q_a, 56'h55);
    portA(11'd100, 1'b0, '0, 1'b0);
    tick(); tick();
    checkEq("hold_qa", q_a, 56'h55);

    // Independent ports at the address extremes
    portA(11'h7FF, 1'b1, 56'h1, 1'b0);
    portB(11'h000, 1'b1, 56'h2, 1'b0);
    tick();
    portA(11'h000, 1'b0, '0, 1'b1);
    portB(11'h7FF, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("indep_qa", q_a, 56'h2);
    checkEq("indep_qb", q_b, 56'h1);

    // Reset mid-operation suppresses the write and clears outputs
    idle(); portA(11'd4, 1'b1, 56'h77, 1'b0);
    tick();
    reset = 1'b1;
    portA(11'd4, 1'b1, 56'h99, 1'b1);
    tick();
    checkEq("midrst_qa", q_a, 56'h0);
    checkEq("midrst_qb", q_b, 56'h0);
    reset = 1'b0;
    idle(); portA(11'd4, 1'b0, '0, 1'b1);
    tick(); settle();
    checkEq("midrst_mem", q_a, 56'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
